// File: rtl/rgb2hsv_pipe_pkg.sv
// Shared constants and types for the RGB<->HSV colour-processing stages.
// The HSV-to-RGB stage imports the same package so both ends agree on formats.
package rgb_hsv_pkg;

    localparam int H_W             = 9;
    localparam int S_W             = 11;
    localparam int V_W             = 8;
    localparam int S_ONE           = 2048;
    localparam int S_MAX           = 2047;
    localparam int HUE_SECTOR      = 60;
    localparam int HUE_FULL        = 360;
    localparam int DIV_NUM_W       = 19;
    localparam int DIV_DEN_W       = 8;
    localparam int RGB2HSV_LATENCY = 22;

    // One-hot selector for the channel holding the maximum (ties r > g > b).
    typedef enum logic [2:0] {
        SEL_R = 3'b001,
        SEL_G = 3'b010,
        SEL_B = 3'b100
    } max_sel_e;

    // Information that rides alongside the dividers.
    typedef struct packed {
        logic           neg;    // hue numerator was negative
        max_sel_e       sel;    // hue sector base
        logic           grey;   // delta == 0
        logic           black;  // max == 0
        logic [V_W-1:0] v;      // value output
    } side_t;

endpackage

// File: rtl/rgb2hsv_pipe_if.sv
// Pixel bus for the RGB-to-HSV converter: RGB in, HSV out, no backpressure.
interface rgb2hsv_pipe_if;
    import rgb_hsv_pkg::*;

    logic [7:0]     r;
    logic [7:0]     g;
    logic [7:0]     b;
    logic           in_valid;
    logic [H_W-1:0] H;
    logic [S_W-1:0] S;
    logic [V_W-1:0] V;
    logic           out_valid;

    modport master (output r, g, b, in_valid, input  H, S, V, out_valid);
    modport slave  (input  r, g, b, in_valid, output H, S, V, out_valid);

endinterface

// File: rtl/rgb2hsv_pipe_div.sv
// Pipelined restoring divider: one quotient bit per stage, MSB first.
// Numerator and denominator are carried alongside the partial remainder, so
// a new division can start every clock. Divide-by-zero yields garbage that
// the caller is expected to discard.
module rgb2hsv_pipe_div
    import rgb_hsv_pkg::*;
(
    input  logic                 clk,
    input  logic [DIV_NUM_W-1:0] num_i,
    input  logic [DIV_DEN_W-1:0] den_i,
    output logic [DIV_NUM_W-1:0] quo_o
);

    localparam int NST = DIV_NUM_W;

    logic [DIV_NUM_W-1:0] num_q [NST-1];
    logic [DIV_DEN_W-1:0] den_q [NST-1];
    logic [DIV_DEN_W-1:0] rem_q [NST-1];
    logic [DIV_NUM_W-1:0] quo_q [NST];

    logic [DIV_NUM_W-1:0] num_s [NST];
    logic [DIV_DEN_W-1:0] den_s [NST];
    logic [DIV_DEN_W-1:0] rem_s [NST];
    logic [DIV_NUM_W-1:0] quo_s [NST];
    logic [DIV_DEN_W-1:0] rem_d [NST];
    logic [DIV_NUM_W-1:0] quo_d [NST];

    // Per-stage trial subtraction of the denominator from the shifted remainder.
    always_comb begin
        logic [DIV_DEN_W:0] trial;
        trial    = '0;
        num_s[0] = num_i;
        den_s[0] = den_i;
        rem_s[0] = '0;
        quo_s[0] = '0;
        for (int s = 1; s < NST; s++) begin
            num_s[s] = num_q[s-1];
            den_s[s] = den_q[s-1];
            rem_s[s] = rem_q[s-1];
            quo_s[s] = quo_q[s-1];
        end
        for (int s = 0; s < NST; s++) begin
            trial = {rem_s[s], num_s[s][NST-1-s]};
            if (trial >= {1'b0, den_s[s]}) begin
                rem_d[s] = DIV_DEN_W'(trial - {1'b0, den_s[s]});
                quo_d[s] = {quo_s[s][DIV_NUM_W-2:0], 1'b1};
            end else begin
                rem_d[s] = trial[DIV_DEN_W-1:0];
                quo_d[s] = {quo_s[s][DIV_NUM_W-2:0], 1'b0};
            end
        end
    end

    // Advance every stage; the final stage only needs its quotient.
    always_ff @(posedge clk) begin
        for (int s = 0; s < NST - 1; s++) begin
            num_q[s] <= num_s[s];
            den_q[s] <= den_s[s];
            rem_q[s] <= rem_d[s];
        end
        for (int s = 0; s < NST; s++) begin
            quo_q[s] <= quo_d[s];
        end
    end

    assign quo_o = quo_q[NST-1];

endmodule

// File: rtl/rgb2hsv_pipe.sv
// Fully pipelined RGB-to-HSV converter, fixed 22-cycle latency, 1 pixel/clock.
// Stage 1 max/min/select, stage 2 delta and numerators, stages 3-21 two
// parallel dividers (hue and saturation), stage 22 assembly and output.
// Optional macro RGB2HSV_HUE_ROUND_EN: round the hue quotient half-up
// instead of truncating it.
module rgb2hsv_pipe
    import rgb_hsv_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    rgb2hsv_pipe_if.slave pix
);

    localparam int DIV_STAGES = DIV_NUM_W;
    localparam int VLD_W      = RGB2HSV_LATENCY - 1;

    // stage 1
    logic [7:0]     r1_q, g1_q, b1_q, max1_q, min1_q;
    max_sel_e       sel1_q;
    logic [7:0]     max_d, min_d;
    max_sel_e       sel_d;

    // stage 2
    logic [DIV_NUM_W-1:0] hue_num_d, hue_num2_q;
    logic [DIV_NUM_W-1:0] sat_num_d, sat_num2_q;
    logic [7:0]           delta_d, delta2_q, max2_q;
    side_t                side_d, side2_q;

    // divider stages and output
    side_t                side_q [DIV_STAGES];
    logic [DIV_NUM_W-1:0] hue_quo, sat_quo;
    logic [VLD_W-1:0]     vld_q;
    logic [H_W-1:0]       h_d, h_q;
    logic [S_W-1:0]       s_d, s_q;
    logic [V_W-1:0]       v_q;
    logic                 out_valid_q;

    // Max channel with r > g > b tie priority, and min.
    always_comb begin
        if (pix.r >= pix.g && pix.r >= pix.b) begin
            sel_d = SEL_R;
            max_d = pix.r;
        end else if (pix.g >= pix.b) begin
            sel_d = SEL_G;
            max_d = pix.g;
        end else begin
            sel_d = SEL_B;
            max_d = pix.b;
        end
        min_d = pix.r;
        if (pix.g < min_d) min_d = pix.g;
        if (pix.b < min_d) min_d = pix.b;
    end

    // Stage 1 registers (datapath, no reset).
    always_ff @(posedge clk) begin
        r1_q   <= pix.r;
        g1_q   <= pix.g;
        b1_q   <= pix.b;
        max1_q <= max_d;
        min1_q <= min_d;
        sel1_q <= sel_d;
    end

    // Delta, hue numerator magnitude/sign, saturation numerator and zero flags.
    always_comb begin
        logic [7:0] pa, pb, absn;
        case (sel1_q)
            SEL_R:   begin pa = g1_q; pb = b1_q; end
            SEL_G:   begin pa = b1_q; pb = r1_q; end
            default: begin pa = r1_q; pb = g1_q; end
        endcase
        absn    = (pa >= pb) ? (pa - pb) : (pb - pa);
        delta_d = max1_q - min1_q;
`ifdef RGB2HSV_HUE_ROUND_EN
        hue_num_d = DIV_NUM_W'(absn) * DIV_NUM_W'(HUE_SECTOR)
                  + DIV_NUM_W'(delta_d >> 1);
`else
        hue_num_d = DIV_NUM_W'(absn) * DIV_NUM_W'(HUE_SECTOR);
`endif
        sat_num_d    = {delta_d, {(DIV_NUM_W - V_W){1'b0}}};
        side_d.neg   = (pa < pb);
        side_d.sel   = sel1_q;
        side_d.grey  = (delta_d == 8'd0);
        side_d.black = (max1_q == 8'd0);
        side_d.v     = max1_q;
    end

    // Stage 2 registers (datapath, no reset).
    always_ff @(posedge clk) begin
        hue_num2_q <= hue_num_d;
        sat_num2_q <= sat_num_d;
        delta2_q   <= delta_d;
        max2_q     <= max1_q;
        side2_q    <= side_d;
    end

    rgb2hsv_pipe_div u_div_hue (
        .clk   (clk),
        .num_i (hue_num2_q),
        .den_i (delta2_q),
        .quo_o (hue_quo)
    );

    rgb2hsv_pipe_div u_div_sat (
        .clk   (clk),
        .num_i (sat_num2_q),
        .den_i (max2_q),
        .quo_o (sat_quo)
    );

    // Side information delay chain matched to the divider depth.
    always_ff @(posedge clk) begin
        side_q[0] <= side2_q;
        for (int s = 1; s < DIV_STAGES; s++) begin
            side_q[s] <= side_q[s-1];
        end
    end

    // Valid shift chain covering stages 1..21; reset drops in-flight pixels.
    always_ff @(posedge clk) begin
        if (rst) vld_q <= '0;
        else     vld_q <= {vld_q[VLD_W-2:0], pix.in_valid};
    end

    // Hue sector assembly with 360->0 wrap, saturation clamp, zero overrides.
    always_comb begin
        logic [DIV_NUM_W-1:0] hue_raw;
        side_t                sd;
        sd = side_q[DIV_STAGES-1];
        case (sd.sel)
            SEL_R:   hue_raw = sd.neg ? DIV_NUM_W'(HUE_FULL) - hue_quo : hue_quo;
            SEL_G:   hue_raw = sd.neg ? DIV_NUM_W'(120) - hue_quo
                                      : DIV_NUM_W'(120) + hue_quo;
            default: hue_raw = sd.neg ? DIV_NUM_W'(240) - hue_quo
                                      : DIV_NUM_W'(240) + hue_quo;
        endcase
        if (hue_raw == DIV_NUM_W'(HUE_FULL)) hue_raw = '0;
        if (sd.grey) begin
            h_d = '0;
            s_d = '0;
        end else begin
            h_d = H_W'(hue_raw);
            s_d = (sat_quo > DIV_NUM_W'(S_MAX)) ? S_W'(S_MAX) : S_W'(sat_quo);
        end
        if (sd.black) s_d = '0;
    end

    // Output register: values change only with a valid pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            h_q         <= '0;
            s_q         <= '0;
            v_q         <= '0;
        end else begin
            out_valid_q <= vld_q[VLD_W-1];
            if (vld_q[VLD_W-1]) begin
                h_q <= h_d;
                s_q <= s_d;
                v_q <= side_q[DIV_STAGES-1].v;
            end
        end
    end

    assign pix.H         = h_q;
    assign pix.S         = s_q;
    assign pix.V         = v_q;
    assign pix.out_valid = out_valid_q;

endmodule

// File: tb/tb_rgb2hsv_pipe.sv
// Self-checking bench for rgb2hsv_pipe: directed pixels, a random stream with
// a mid-stream reset, and a cycle-indexed expectation table from a plain
// arithmetic HSV model.
module tb_rgb2hsv_pipe;
    import rgb_hsv_pkg::*;

    localparam int MAXC = 1024;
    localparam int LAT  = 22;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rgb2hsv_pipe_if pix ();

    rgb2hsv_pipe dut (
        .clk (clk),
        .rst (rst),
        .pix (pix)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit exp_vld [MAXC];
    bit exp_rst [MAXC];
    int exp_h   [MAXC];
    int exp_s   [MAXC];
    int exp_v   [MAXC];

    int checks = 0;
    int errors = 0;
    int last_h = 0, last_s = 0, last_v = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s cycle %0d got %0d expected %0d", name, cyc, act, req);
        end
    endtask

    // HSV as defined arithmetically on whole numbers.
    function automatic void model(input int r, input int g, input int b,
                                  output int h, output int s, output int v);
        int mx, mn, d, n, base, an, q;
        mx = r; if (g > mx) mx = g; if (b > mx) mx = b;
        mn = r; if (g < mn) mn = g; if (b < mn) mn = b;
        d  = mx - mn;
        v  = mx;
        if (r >= g && r >= b) begin n = g - b; base = 0;   end
        else if (g >= b)      begin n = b - r; base = 120; end
        else                  begin n = r - g; base = 240; end
        an = (n < 0) ? -n : n;
        if (d == 0 || mx == 0) begin
            h = 0;
            s = 0;
        end else begin
`ifdef RGB2HSV_HUE_ROUND_EN
            q = (60 * an + d / 2) / d;
`else
            q = (60 * an) / d;
`endif
            h = (n < 0) ? base - q : base + q;
            if (h < 0)    h += 360;
            if (h >= 360) h -= 360;
            s = (d * 2048) / mx;
            if (s > 2047) s = 2047;
        end
    endfunction

    task automatic mark_rst(input int n);
        if (n + 1 < MAXC) exp_rst[n+1] = 1'b1;
        for (int k = n + 1; k <= n + LAT && k < MAXC; k++) exp_vld[k] = 1'b0;
    endtask

    // Present one cycle of input, record what must appear LAT cycles later.
    task automatic drive(input bit v, input int r, input int g, input int b, input bit rs);
        int h, s, vv;
        rst          = rs;
        pix.in_valid = v;
        pix.r        = 8'(r);
        pix.g        = 8'(g);
        pix.b        = 8'(b);
        if (rs) begin
            mark_rst(cyc);
        end else if (v && cyc + LAT < MAXC) begin
            model(r, g, b, h, s, vv);
            exp_vld[cyc+LAT] = 1'b1;
            exp_h[cyc+LAT]   = h;
            exp_s[cyc+LAT]   = s;
            exp_v[cyc+LAT]   = vv;
        end
        @(posedge clk);
        #1;
    endtask

    // Compare DUT outputs against the expectation table every cycle.
    always @(negedge clk) begin
        if (cyc >= 1 && cyc < MAXC) begin
            if (exp_rst[cyc]) begin
                last_h = 0; last_s = 0; last_v = 0;
            end
            if (exp_vld[cyc]) begin
                last_h = exp_h[cyc]; last_s = exp_s[cyc]; last_v = exp_v[cyc];
            end
            check("out_valid", int'(pix.out_valid), int'(exp_vld[cyc]));
            check("H", int'(pix.H), last_h);
            check("S", int'(pix.S), last_s);
            check("V", int'(pix.V), last_v);
        end
    end

    typedef struct {
        int r, g, b, h, s, v;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int mh, ms, mv, rh;
`ifdef RGB2HSV_HUE_ROUND_EN
        rh = 22;
`else
        rh = 21;
`endif
        vecs[0] = '{255,   0,   0,   0, 2047, 255};
        vecs[1] = '{  0, 255,   0, 120, 2047, 255};
        vecs[2] = '{  0,   0, 255, 240, 2047, 255};
        vecs[3] = '{128, 128, 128,   0,    0, 128};
        vecs[4] = '{  0,   0,   0,   0,    0,   0};
        vecs[5] = '{200, 100,  50,  20, 1536, 200};
        vecs[6] = '{255,   0, 128, 330, 2047, 255};
        vecs[7] = '{255,   0,   1,   0, 2047, 255};
        vecs[8] = '{200, 104,  50,  rh, 1536, 200};
        vecs[9] = '{200, 200,  50,  60, 1536, 200};

        pix.in_valid = 1'b0;
        pix.r = '0; pix.g = '0; pix.b = '0;
        for (int i = 0; i < 4; i++) drive(1'b0, 0, 0, 0, 1'b1);

        // Hand-computed values pin the model itself.
        for (int i = 0; i < 10; i++) begin
            model(vecs[i].r, vecs[i].g, vecs[i].b, mh, ms, mv);
            check($sformatf("model_h%0d", i), mh, vecs[i].h);
            check($sformatf("model_s%0d", i), ms, vecs[i].s);
            check($sformatf("model_v%0d", i), mv, vecs[i].v);
        end

        // Isolated pulses: latency and per-pixel values.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, vecs[i].r, vecs[i].g, vecs[i].b, 1'b0);
            for (int k = 0; k < LAT + 3; k++) drive(1'b0, 0, 0, 0, 1'b0);
        end

        // Back-to-back burst of the same vectors.
        for (int i = 0; i < 10; i++) drive(1'b1, vecs[i].r, vecs[i].g, vecs[i].b, 1'b0);
        for (int k = 0; k < 5; k++) drive(1'b0, 0, 0, 0, 1'b0);

        // Random stream with random gaps and a one-cycle reset at pixel 20.
        for (int i = 0; i < 40; i++) begin
            if (i == 20) drive(1'b0, 0, 0, 0, 1'b1);
            else drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
                       int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'b0);
        end
        for (int k = 0; k < LAT + 8; k++) drive(1'b0, 0, 0, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
